// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants and state type for the ALU execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_DW    = 32;
    localparam int ALU_NREG  = 16;
    localparam int ALU_AW    = $clog2(ALU_NREG);
    localparam int ALU_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_regfile.sv
// ============================================================================
// Module   : alu_regfile
// Purpose  : NREG x DW register file, three async read ports, one sync write
//            port, R0 hard-wired to zero, async active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [AW-1:0] rc_addr,
    output logic [DW-1:0] rc_data
);

    logic [DW-1:0] r_mem [NREG];

    // R0 is never written, so it stays at its cleared value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : r_mem[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : r_mem[rb_addr];
    assign rc_data = (rc_addr == '0) ? '0 : r_mem[rc_addr];

endmodule : alu_regfile

`default_nettype wire

// File: rtl/alu_exec_stage.sv
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Operand-fetch / write-back sequencer around an external 32-bit
//            ALU; one op per handshake, operands from an internal register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DW   = ALU_DW,
    parameter int NREG = ALU_NREG,
    parameter int AW   = ALU_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_SEL_W-1:0] in_sel,
    input  logic [AW-1:0]        in_rs,
    input  logic [AW-1:0]        in_rt,
    input  logic [AW-1:0]        in_rd,
    input  logic                 in_we,
    output logic [DW-1:0]        alu_a,
    output logic [DW-1:0]        alu_b,
    output logic [ALU_SEL_W-1:0] alu_sel,
    input  logic [DW-1:0]        alu_out,
    input  logic                 alu_carry,
    output logic                 done,
    output logic                 carry_flag,
    input  logic                 dbg_we,
    input  logic [AW-1:0]        dbg_addr,
    input  logic [DW-1:0]        dbg_wdata,
    output logic [DW-1:0]        dbg_rdata
);

    state_t                 r_state;
    state_t                 w_next;

    logic [ALU_SEL_W-1:0]   r_sel;
    logic [AW-1:0]          r_rs;
    logic [AW-1:0]          r_rt;
    logic [AW-1:0]          r_rd;
    logic                   r_we;
    logic [DW-1:0]          r_alu_a;
    logic [DW-1:0]          r_alu_b;
    logic [ALU_SEL_W-1:0]   r_alu_sel;
    logic [DW-1:0]          r_res;
    logic                   r_cy;
    logic                   r_carry_flag;

    logic [DW-1:0]          w_rs_data;
    logic [DW-1:0]          w_rt_data;
    logic                   w_rf_we;
    logic [AW-1:0]          w_rf_waddr;
    logic [DW-1:0]          w_rf_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = READ;
            READ:    w_next = EXEC;
            EXEC:    w_next = WB;
            WB:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_we         <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_res        <= '0;
            r_cy         <= 1'b0;
            r_carry_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sel <= in_sel;
                        r_rs  <= in_rs;
                        r_rt  <= in_rt;
                        r_rd  <= in_rd;
                        r_we  <= in_we;
                    end
                end
                READ: begin
                    r_alu_a   <= w_rs_data;
                    r_alu_b   <= w_rt_data;
                    r_alu_sel <= r_sel;
                end
                EXEC: begin
                    r_res <= alu_out;
                    r_cy  <= alu_carry;
                end
                WB: begin
                    r_carry_flag <= r_cy;
                end
                default: ;
            endcase
        end
    end

    // Write-back owns the port in WB; a debug preload only lands in an IDLE
    // cycle that is not also accepting an op.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = dbg_addr;
        w_rf_wdata = dbg_wdata;
        if (r_state == WB) begin
            w_rf_we    = r_we;
            w_rf_waddr = r_rd;
            w_rf_wdata = r_res;
        end else if ((r_state == IDLE) && dbg_we && !in_valid) begin
            w_rf_we    = 1'b1;
        end
    end

    alu_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (w_rf_we),
        .waddr   (w_rf_waddr),
        .wdata   (w_rf_wdata),
        .ra_addr (r_rs),
        .ra_data (w_rs_data),
        .rb_addr (r_rt),
        .rb_data (w_rt_data),
        .rc_addr (dbg_addr),
        .rc_data (dbg_rdata)
    );

    assign in_ready   = (r_state == IDLE);
    assign done       = (r_state == WB);
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign carry_flag = r_carry_flag;

endmodule : alu_exec_stage

`default_nettype wire
